// File: rtl/cmdq_issue_pkg.sv
// Shared types and helpers for the command-queue issue/replay controller.
package cmdq_issue_pkg;

  // Width of the performance counters.
  localparam int PERF_W = 32;

  // Watchdog FSM states. The FSM only observes the issue logic.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HANG  = 2'd2
  } state_e;

  // Bits needed to hold a credit count in the range 0..depth.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cmdq_issue_ctrl_if.sv
// Decoder / downstream-queue signal bundle for cmdq_issue_ctrl.
// The master side is the decoder plus the queues; the slave side is the controller.
interface cmdq_issue_ctrl_if
  import cmdq_issue_pkg::*;
#(
  parameter int NQ    = 2,
  parameter int DEPTH = 4
) ();

  localparam int CW = credit_w(DEPTH);

  logic                 io_valid;
  logic [NQ-1:0]        io_enq_mask;
  logic                 io_issue;
  logic                 io_replay;
  logic [NQ-1:0]        io_q_enq;
  logic [NQ-1:0]        io_q_deq;
  logic [NQ*CW-1:0]     io_credits;
  logic                 io_hang;
  logic                 io_ovf_err;
  logic [PERF_W-1:0]    io_perf_issue;
  logic [PERF_W-1:0]    io_perf_replay;

  modport master (
    output io_valid, io_enq_mask, io_q_deq,
    input  io_issue, io_replay, io_q_enq, io_credits, io_hang, io_ovf_err,
           io_perf_issue, io_perf_replay
  );

  modport slave (
    input  io_valid, io_enq_mask, io_q_deq,
    output io_issue, io_replay, io_q_enq, io_credits, io_hang, io_ovf_err,
           io_perf_issue, io_perf_replay
  );

endinterface

// File: rtl/cmdq_credit_ctr.sv
// Per-queue credit counter. Starts full (DEPTH credits), spends one per enqueue,
// regains one per dequeue. A dequeue against a full counter is reported as an
// overflow pulse and the count holds at DEPTH.
module cmdq_credit_ctr
  import cmdq_issue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = credit_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enq,
  input  logic          deq,
  output logic [CW-1:0] count,
  output logic          ovf
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_q;
  logic          at_full;

  assign at_full = (count_q == FULL);
  assign ovf     = deq & ~enq & at_full;
  assign count   = count_q;

  // Credit register: enqueue+dequeue in one cycle cancel out; no bypass of returns.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= FULL;
    end else if (enq && !deq) begin
      count_q <= count_q - ONE;
    end else if (deq && !enq && !at_full) begin
      count_q <= count_q + ONE;
    end
  end

endmodule

// File: rtl/cmdq_issue_ctrl.sv
// Issue/replay controller between an instruction decoder and NQ command queues.
// An instruction fires only when every targeted queue holds a credit; otherwise
// the decoder replays it. A watchdog FSM flags instructions stuck in replay.
// Optional build macro CMDQ_ISSUE_PERF_EN adds issue/replay performance counters;
// without it the perf ports read zero and no counter flops exist.
module cmdq_issue_ctrl
  import cmdq_issue_pkg::*;
#(
  parameter int NQ         = 2,
  parameter int DEPTH      = 4,
  parameter int REPLAY_MAX = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  cmdq_issue_ctrl_if.slave   io
);

  localparam int CW = credit_w(DEPTH);
  localparam int SW = $clog2(REPLAY_MAX + 1);

  localparam logic [SW-1:0] CNT_MAX = SW'(REPLAY_MAX);
  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  logic [CW-1:0] credit [NQ];
  logic [NQ-1:0] ok;
  logic [NQ-1:0] ovf_pulse;
  logic          issue;
  logic          replay;

  state_e        state_q, state_d;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic          hang_set;
  logic          hang_q;
  logic          ovf_q;

  // ---------------------------------------------------------------------------
  // Credit counters and per-queue readiness
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NQ; gi++) begin : g_q
    cmdq_credit_ctr #(.DEPTH(DEPTH)) u_ctr (
      .clk     (clk),
      .reset_n (reset_n),
      .enq     (io.io_q_enq[gi]),
      .deq     (io.io_q_deq[gi]),
      .count   (credit[gi]),
      .ovf     (ovf_pulse[gi])
    );

    assign io.io_credits[gi*CW +: CW] = credit[gi];
    assign ok[gi] = ~io.io_enq_mask[gi] | (credit[gi] != '0);
  end

  // All-or-nothing issue: an empty mask issues unconditionally.
  assign issue        = io.io_valid & (&ok);
  assign replay       = io.io_valid & ~issue;
  assign io.io_issue  = issue;
  assign io.io_replay = replay;
  assign io.io_q_enq  = io.io_enq_mask & {NQ{issue}};

  // ---------------------------------------------------------------------------
  // Replay watchdog FSM
  // ---------------------------------------------------------------------------

  // State register and stall counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state: count consecutive replay cycles, leave on issue or withdrawal.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      RUN: begin
        if (replay) begin
          stall_cnt_d = CNT_ONE;
          state_d     = (CNT_ONE == CNT_MAX) ? HANG : STALL;
        end
      end
      STALL: begin
        if (!replay) begin
          state_d     = RUN;
          stall_cnt_d = '0;
        end else begin
          stall_cnt_d = (stall_cnt_q == CNT_MAX) ? CNT_MAX : stall_cnt_q + CNT_ONE;
          if (stall_cnt_d == CNT_MAX) state_d = HANG;
        end
      end
      HANG: begin
        if (!replay) begin
          state_d     = RUN;
          stall_cnt_d = '0;
        end else begin
          stall_cnt_d = (stall_cnt_q == CNT_MAX) ? CNT_MAX : stall_cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d     = RUN;
        stall_cnt_d = '0;
      end
    endcase
  end

  // FSM output: raise the hang flag on entry into HANG.
  always_comb begin
    hang_set = (state_d == HANG) && (state_q != HANG);
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hang_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      hang_q <= hang_q | hang_set;
      ovf_q  <= ovf_q | (|ovf_pulse);
    end
  end

  assign io.io_hang    = hang_q;
  assign io.io_ovf_err = ovf_q;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef CMDQ_ISSUE_PERF_EN
  logic [PERF_W-1:0] perf_issue_q;
  logic [PERF_W-1:0] perf_replay_q;

  // Free-running event counters, wrapping modulo 2^PERF_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_q  <= '0;
      perf_replay_q <= '0;
    end else begin
      if (issue)  perf_issue_q  <= perf_issue_q + PERF_W'(1);
      if (replay) perf_replay_q <= perf_replay_q + PERF_W'(1);
    end
  end

  assign io.io_perf_issue  = perf_issue_q;
  assign io.io_perf_replay = perf_replay_q;
`else
  assign io.io_perf_issue  = '0;
  assign io.io_perf_replay = '0;
`endif

endmodule

// File: tb/tb_cmdq_issue_ctrl.sv
// Directed self-checking bench for cmdq_issue_ctrl (NQ=2, DEPTH=4, REPLAY_MAX=15).
// Per-cycle expected issue/replay/enqueue results go through a scoreboard queue.
module tb_cmdq_issue_ctrl;
  import cmdq_issue_pkg::*;

  localparam int NQ = 2;
  localparam int DEPTH = 4;
  localparam int REPLAY_MAX = 15;

  logic clk;
  logic reset_n;

  cmdq_issue_ctrl_if #(.NQ(NQ), .DEPTH(DEPTH)) bus ();

  cmdq_issue_ctrl #(.NQ(NQ), .DEPTH(DEPTH), .REPLAY_MAX(REPLAY_MAX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       issue;
    logic       replay;
    logic [1:0] enq;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   n_issue = 0;
  int   n_replay = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one decoder/queue cycle and compare the combinational response.
  task automatic apply(input logic v, input logic [1:0] m, input logic [1:0] d,
                       input logic ei, input logic er, input logic [1:0] ee,
                       input string tag);
    exp_t e;
    e.issue = ei; e.replay = er; e.enq = ee; e.tag = tag;
    sb.push_back(e);
    bus.io_valid    = v;
    bus.io_enq_mask = m;
    bus.io_q_deq    = d;
    #1;
    e = sb.pop_front();
    check({e.tag, ".issue"},  64'(bus.io_issue),  64'(e.issue));
    check({e.tag, ".replay"}, 64'(bus.io_replay), 64'(e.replay));
    check({e.tag, ".q_enq"},  64'(bus.io_q_enq),  64'(e.enq));
    if (ei) n_issue++;
    if (er) n_replay++;
  endtask

  task automatic check_regs(input string tag, input int c0, input int c1,
                            input logic hang, input logic ovf, input state_e st);
    check({tag, ".credit0"}, 64'(bus.io_credits[2:0]), 64'(c0));
    check({tag, ".credit1"}, 64'(bus.io_credits[5:3]), 64'(c1));
    check({tag, ".hang"},    64'(bus.io_hang),         64'(hang));
    check({tag, ".ovf_err"}, 64'(bus.io_ovf_err),      64'(ovf));
    check({tag, ".state"},   64'(dut.state_q),         64'(st));
  endtask

  task automatic check_perf(input string tag);
    int ei, er;
`ifdef CMDQ_ISSUE_PERF_EN
    ei = n_issue;
    er = n_replay;
`else
    ei = 0;
    er = 0;
`endif
    check({tag, ".perf_issue"},  64'(bus.io_perf_issue),  64'(ei));
    check({tag, ".perf_replay"}, 64'(bus.io_perf_replay), 64'(er));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n         = 1'b0;
    bus.io_valid    = 1'b0;
    bus.io_enq_mask = '0;
    bus.io_q_deq    = '0;
    cyc();
    check_regs("reset", 4, 4, 1'b0, 1'b0, RUN);
    check_perf("reset");
    reset_n = 1'b1;

    // 1: four full-mask issues drain both queues, fifth is replayed.
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 2'b11, "t1_issue");
      cyc();
    end
    check_regs("t1_drained", 0, 0, 1'b0, 1'b0, RUN);
    apply(1'b1, 2'b11, 2'b00, 1'b0, 1'b1, 2'b00, "t1_replay");
    cyc();
    check_regs("t1_stall", 0, 0, 1'b0, 1'b0, STALL);

    // Withdraw and return three credits to q1; withdrawal leaves STALL.
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 2'b00, "t2_refill");
      cyc();
    end
    check_regs("t2_pre", 0, 3, 1'b0, 1'b0, RUN);

    // 2: mask targets only q1, which has credit.
    apply(1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 2'b10, "t2_issue");
    cyc();
    check_regs("t2_post", 0, 2, 1'b0, 1'b0, RUN);

    // Empty mask issues even with q0 empty.
    apply(1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, "mask0_issue");
    cyc();

    // 3: credit returned at t is usable only at t+1.
    apply(1'b1, 2'b01, 2'b01, 1'b0, 1'b1, 2'b00, "t3_nobypass");
    cyc();
    check_regs("t3_t1", 1, 2, 1'b0, 1'b0, STALL);
    apply(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, "t3_issue");
    cyc();
    check_regs("t3_t2", 0, 2, 1'b0, 1'b0, RUN);

    // 4: enqueue and dequeue of q1 in one cycle leave its credit unchanged.
    apply(1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 2'b10, "t4_enqdeq");
    cyc();
    check_regs("t4_same", 0, 2, 1'b0, 1'b0, RUN);
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 2'b00, "t4_fill");
      cyc();
    end
    check_regs("t4_full", 0, 4, 1'b0, 1'b0, RUN);
    apply(1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 2'b00, "t4_ovf");
    cyc();
    check_regs("t4_ovf", 0, 4, 1'b0, 1'b1, RUN);
    apply(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, "t4_idle");
    cyc();
    check_regs("t4_sticky", 0, 4, 1'b0, 1'b1, RUN);

    // 5: blocked instruction held for REPLAY_MAX cycles trips the watchdog.
    for (int i = 1; i <= REPLAY_MAX; i++) begin
      apply(1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 2'b00, "t5_blocked");
      cyc();
      if (i == REPLAY_MAX - 1) check("t5_hang_early", 64'(bus.io_hang), 64'(0));
    end
    check_regs("t5_hang", 0, 4, 1'b1, 1'b1, HANG);
    apply(1'b1, 2'b01, 2'b01, 1'b0, 1'b1, 2'b00, "t5_grant");
    cyc();
    check_regs("t5_granted", 1, 4, 1'b1, 1'b1, HANG);
    apply(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, "t5_issue");
    cyc();
    check_regs("t5_run", 0, 4, 1'b1, 1'b1, RUN);
    check_perf("t5_perf");

    // 6: asynchronous reset in the middle of a stall.
    apply(1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 2'b00, "t6_stall");
    cyc();
    check("t6_state_stall", 64'(dut.state_q), 64'(STALL));
    #2;
    reset_n = 1'b0;
    #1;
    n_issue  = 0;
    n_replay = 0;
    check_regs("t6_async", 4, 4, 1'b0, 1'b0, RUN);
    check_perf("t6_async");
    bus.io_valid    = 1'b0;
    bus.io_enq_mask = '0;
    bus.io_q_deq    = '0;
    cyc();
    reset_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, "t6_issue");
      cyc();
    end
    check_regs("t6_3issue", 1, 4, 1'b0, 1'b0, RUN);
    check_perf("t6_3issue");
    apply(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, "t6_issue4");
    cyc();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 2'b00, "t6_replay");
      cyc();
    end
    check_regs("t6_end", 0, 4, 1'b0, 1'b0, STALL);
    check_perf("t6_end");
    apply(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, "t6_idle");
    cyc();
    check("t6_withdraw", 64'(dut.state_q), 64'(RUN));

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
